vc_credit_flow_control: RTL
===========================

// Module: vc_credit_flow_control
// PURPOSE
//   Multi-virtual-channel credit-based flow controller for the NoC link layer.
//   Each VC has a 2-entry input skid buffer and a credit counter. Eligible VCs
//   are round-robin arbitrated onto one registered output with valid/ready
//   handshake. The downstream router returns credits per VC.
// PARAMETERS
//   DATA_W       16  flit width in bits
//   NUM_VC       4   number of virtual channels (>=2)
//   MAX_CREDITS  8   credit counter ceiling per VC (downstream buffer depth)
//   INIT_CREDITS 8   per-VC credit count loaded at reset (<= MAX_CREDITS)
//   VC_W         $clog2(NUM_VC), CREDIT_W $clog2(MAX_CREDITS+1)  (derived)
// PORTS
//   clk         in   1                 clock, all logic on rising edge
//   rst_n       in   1                 asynchronous active-low reset
//   in_data     in   NUM_VC*DATA_W     per-VC flit, VC v at [v*DATA_W +: DATA_W]
//   in_valid    in   NUM_VC            per-VC flit valid
//   in_ready    out  NUM_VC            per-VC buffer can accept
//   out_data    out  DATA_W            granted flit
//   out_vc      out  VC_W              VC id of out_data
//   out_valid   out  1                 output flit valid
//   out_ready   in   1                 downstream accepts output flit
//   credit_ret  in   NUM_VC            one-cycle pulse per returned credit, per VC
//   credit_cnt  out  NUM_VC*CREDIT_W   current credit count per VC
//   credit_err  out  1                 sticky: credit returned at MAX_CREDITS
// BEHAVIOUR
//   Reset: buffers empty, in_ready all 1, out_valid 0, out_data 0, out_vc 0,
//     credit_cnt[v]=INIT_CREDITS, credit_err 0, RR pointer=NUM_VC-1 (VC0 first).
//   Input: flit on VC v is written when in_valid[v]&&in_ready[v].
//     in_ready[v] = (occupancy[v] < 2). It is driven from registered state only.
//   Eligible[v] = buffer v non-empty && credit_cnt[v] > 0.
//   Load condition: load = (!out_valid || out_ready) && |eligible.
//   On load: grant the first eligible VC searching from ptr+1 mod NUM_VC.
//     The head of that VC moves into out_data/out_vc, out_valid<=1, ptr<=grant,
//     and that VC's credit is decremented.
//   The RR pointer changes only on a grant.
//   If out_valid&&out_ready&&!load, then out_valid<=0. out_data holds its value.
//   Latency: a flit accepted at edge N is earliest out_valid after edge N+1.
//     Aggregate throughput is 1 flit/cycle with out_ready held high.
//   Credits, per VC per cycle:
//     ret only          -> +1
//     consume only      -> -1
//     ret and consume   -> unchanged
//   Credit ret when count==MAX_CREDITS and no consume -> count holds and
//     credit_err<=1. credit_err is cleared only by reset.
//   A VC with count 0 is never granted. Its buffer fills, then in_ready[v]=0.
//     Other VCs are unaffected (no head-of-line blocking across VCs).
//   Buffer write and read on the same VC in the same cycle: occupancy holds,
//     FIFO order is preserved.
//   Output stall (out_valid&&!out_ready): out_data/out_vc are stable, no grant,
//     no credit consumed.
//   Reset asserted mid-operation: all state returns to reset values
//     asynchronously. Flits in flight are discarded.
// TESTING
//   1. Reset -> credit_cnt all 8, in_ready=4'b1111, out_valid=0, credit_err=0.
//   2. Single flit 16'hA5A5 on VC2, out_ready=1 -> out_valid after 2 edges,
//      out_vc=2, credit_cnt[2]=7.
//   3. All 4 VCs send continuously, out_ready=1 -> out_vc sequence 0,1,2,3,0,...
//      Each credit_cnt reaches 0 after 8 flits, then out_valid drops.
//   4. VC1 at 0 credits, VC0 streaming -> VC0 continues. in_ready[1]=0 after
//      2 flits. One credit_ret[1] pulse -> exactly one VC1 flit is sent.
//   5. out_ready=0 for 5 cycles with traffic -> out_data stable, credit_cnt
//      unchanged. Releasing it resumes with no loss or duplication (check order).
//   6. credit_ret[3] with credit_cnt[3]=8 -> count stays 8, credit_err=1.
//      Simultaneous ret and consume on VC0 -> count unchanged. rst_n pulse
//      mid-stream -> reset values.

Source files
------------

// File: rtl/vc_credit_flow_control.sv
`default_nettype none
// ============================================================================
// Module      : vc_credit_flow_control
// Description : Multi-VC credit-based flow controller for the NoC link layer.
//               Each VC owns a 2-entry skid buffer and a credit counter.
//               Eligible VCs (data present and credit available) are
//               round-robin arbitrated onto one registered valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_credit_flow_control #(
  parameter int DATA_W       = 16,
  parameter int NUM_VC       = 4,
  parameter int MAX_CREDITS  = 8,
  parameter int INIT_CREDITS = 8,
  parameter int VC_W         = $clog2(NUM_VC),
  parameter int CREDIT_W     = $clog2(MAX_CREDITS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_VC*DATA_W-1:0]   in_data,
  input  logic [NUM_VC-1:0]          in_valid,
  output logic [NUM_VC-1:0]          in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [VC_W-1:0]            out_vc,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic [NUM_VC-1:0]          credit_ret,
  output logic [NUM_VC*CREDIT_W-1:0] credit_cnt,
  output logic                       credit_err
);

  localparam logic [CREDIT_W-1:0] C_MAX_CREDITS  = CREDIT_W'(MAX_CREDITS);
  localparam logic [CREDIT_W-1:0] C_INIT_CREDITS = CREDIT_W'(INIT_CREDITS);
  localparam logic [VC_W-1:0]     C_PTR_RESET    = VC_W'(NUM_VC - 1);

  logic [NUM_VC-1:0]        w_elig;
  logic [NUM_VC-1:0]        w_wr;
  logic [NUM_VC-1:0]        w_rd;
  logic [NUM_VC-1:0]        w_err_set;
  logic [NUM_VC*DATA_W-1:0] w_head;
  logic [DATA_W-1:0]        w_head_sel;
  logic [VC_W-1:0]          w_grant;
  logic                     w_found;
  logic                     w_load;

  logic [VC_W-1:0]          r_rr_ptr;
  logic [DATA_W-1:0]        r_out_data;
  logic [VC_W-1:0]          r_out_vc;
  logic                     r_out_valid;
  logic                     r_credit_err;

  // Round-robin search: first eligible VC starting just after the last grant.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_VC; i++) begin
      idx = (int'(r_rr_ptr) + i) % NUM_VC;
      for (int v = 0; v < NUM_VC; v++) begin
        if (!w_found && (v == idx) && w_elig[v]) begin
          w_grant = VC_W'(v);
          w_found = 1'b1;
        end
      end
    end
  end

  // Select the head flit of the granted VC.
  always_comb begin
    w_head_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_grant == VC_W'(v)) begin
        w_head_sel = w_head[v*DATA_W +: DATA_W];
      end
    end
  end

  // Output register is free when empty or being drained this cycle.
  assign w_load = (!r_out_valid || out_ready) && w_found;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [DATA_W-1:0]   r_mem0;
    logic [DATA_W-1:0]   r_mem1;
    logic                r_wp;
    logic                r_rp;
    logic [1:0]          r_occ;
    logic [CREDIT_W-1:0] r_cnt;

    // Ready depends only on registered occupancy, never on downstream state.
    assign in_ready[v]  = (r_occ != 2'd2);
    assign w_wr[v]      = in_valid[v] && in_ready[v];
    assign w_rd[v]      = w_load && (w_grant == VC_W'(v));
    assign w_elig[v]    = (r_occ != 2'd0) && (r_cnt != '0);
    assign w_head[v*DATA_W +: DATA_W] = r_rp ? r_mem1 : r_mem0;
    assign credit_cnt[v*CREDIT_W +: CREDIT_W] = r_cnt;
    // A return that would push the counter past the ceiling is an error.
    assign w_err_set[v] = credit_ret[v] && !w_rd[v] && (r_cnt == C_MAX_CREDITS);

    // Flit storage; contents are don't-care while the entry is empty.
    always_ff @(posedge clk) begin
      if (w_wr[v]) begin
        if (r_wp) r_mem1 <= in_data[v*DATA_W +: DATA_W];
        else      r_mem0 <= in_data[v*DATA_W +: DATA_W];
      end
    end

    // Buffer pointers and occupancy; simultaneous write and read holds occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wp  <= 1'b0;
        r_rp  <= 1'b0;
        r_occ <= 2'd0;
      end else begin
        if (w_wr[v]) r_wp <= ~r_wp;
        if (w_rd[v]) r_rp <= ~r_rp;
        case ({w_wr[v], w_rd[v]})
          2'b10:   r_occ <= r_occ + 2'd1;
          2'b01:   r_occ <= r_occ - 2'd1;
          default: r_occ <= r_occ;
        endcase
      end
    end

    // Credit counter: return and consume in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= C_INIT_CREDITS;
      end else if (credit_ret[v] && !w_rd[v]) begin
        if (r_cnt != C_MAX_CREDITS) r_cnt <= r_cnt + 1'b1;
      end else if (w_rd[v] && !credit_ret[v]) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Registered output stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_vc    <= '0;
      r_rr_ptr    <= C_PTR_RESET;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_head_sel;
      r_out_vc    <= w_grant;
      r_rr_ptr    <= w_grant;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky credit overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit_err <= 1'b0;
    end else if (|w_err_set) begin
      r_credit_err <= 1'b1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_vc     = r_out_vc;
  assign credit_err = r_credit_err;

endmodule
`default_nettype wire
